// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - RV32I multicycle control constants, ALU codes and state encoding
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1111;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b0011;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP, S_EXEC_JALR,
        S_EXEC_LUI, S_EXEC_AUIPC
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALU op class and funct fields to the 4-bit ALU code and branch inversion
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_op_e     alu_op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        op5_i,
    output logic [3:0]  alu_control_o,
    output logic        br_inv_o
);

    // BNE/BLT/BLTU take the branch when the compare result is non-zero
    assign br_inv_o = funct3_i[0] ^ funct3_i[2];

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_BRANCH: begin
                case (funct3_i[2:1])
                    2'b10:   alu_control_o = ALU_SLT;
                    2'b11:   alu_control_o = ALU_SLTU;
                    default: alu_control_o = ALU_SUB;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b011:  alu_control_o = ALU_SLTU;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multicycle control FSM driving datapath muxes, strobes and ALU code
module multicycle_control
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_control,
    output logic        illegal
);

    state_e      state_q, state_d;
    alu_op_e     alu_op;
    logic        alu_en;
    logic [3:0]  dec_alu;
    logic        br_inv;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (instr[30]),
        .op5_i         (opcode[5]),
        .alu_control_o (dec_alu),
        .br_inv_o      (br_inv)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = ALUOP_ADD;
        alu_en     = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        imm_src    = IMM_I;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                alu_en     = 1'b1;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // speculative branch target lands in ALUOut for the BRANCH state
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_B;
                alu_en    = 1'b1;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_OP:             state_d = S_EXEC_R;
                    OP_IMM:            state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JUMP;
                    OP_JALR:           state_d = S_EXEC_JALR;
                    OP_LUI:            state_d = S_EXEC_LUI;
                    OP_AUIPC:          state_d = S_EXEC_AUIPC;
                    OP_BRANCH: begin
                        if (funct3[2:1] == 2'b01) begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_BRANCH;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_src   = opcode[5] ? IMM_S : IMM_I;
                alu_en    = 1'b1;
                state_d   = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = (state_q == S_EXEC_I) ? SRC_B_IMM : SRC_B_RS2;
                alu_op    = ALUOP_FUNCT;
                alu_en    = 1'b1;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALUOP_BRANCH;
                alu_en    = 1'b1;
                pc_write  = zero ^ br_inv;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                alu_en    = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_ALU_WB;
            end
            S_EXEC_JALR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_en    = 1'b1;
                state_d   = S_JUMP;
            end
            S_EXEC_LUI, S_EXEC_AUIPC: begin
                alu_src_a = (state_q == S_EXEC_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_U;
                alu_en    = 1'b1;
                state_d   = S_ALU_WB;
            end
            default: state_d = S_FETCH;
        endcase

        alu_control = alu_en ? dec_alu : 4'b0000;

        // outputs must fall the moment reset asserts, not at the next edge
        if (!resetn) begin
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            imm_src     = 3'b000;
            alu_control = 4'b0000;
            illegal     = 1'b0;
        end
    end

endmodule
